// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
// Holds the default bit period, the command byte codes and the receive FSM state encoding.
// No ports; import with uart_pkg::*.
package uart_pkg;

    // 9600 baud from a 50 MHz clock
    localparam int unsigned CLKS_PER_BIT_DEF = 5208;

    // Command byte codes
    localparam logic [7:0] CMD_START_DEF = 8'h53;  // 'S' : start a measurement
    localparam logic [7:0] CMD_T0_DEF    = 8'h30;  // '0' : 0.1 s frame
    localparam logic [7:0] CMD_T1_DEF    = 8'h31;  // '1' : 1 s frame

    // Receive FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_BREAK_WAIT = 3'd4
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
// Ports: clk_i clock, rst_ni async active-low reset, d_i async input, q_o synchronized output.
// Latency: two clk_i cycles. Both flops reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with single-byte command decode (start, 0.1 s frame, 1 s frame).
// Ports: clk_in clock, reset async active-low, Rx_in serial line (idle high); data_out last good byte,
//        rx_valid/frame_err/start_cmd/unknown_cmd one-cycle pulses, T_frame_sel level, busy = FSM not idle.
// Latency: rx_valid about 9.5 bit times + 3 cycles after the start-bit falling edge. No backpressure.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [7:0]  CMD_START    = CMD_START_DEF,
    parameter logic [7:0]  CMD_T0       = CMD_T0_DEF,
    parameter logic [7:0]  CMD_T1       = CMD_T1_DEF
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       Rx_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       start_cmd,
    output logic       T_frame_sel,
    output logic       unknown_cmd,
    output logic       busy
);

    // Sample points: middle of the start bit, then one full bit period apart.
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    logic       rx_s;

    rx_state_e  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        rx_valid_q;
    logic        frame_err_q;
    logic        start_cmd_q;
    logic        unknown_cmd_q;
    logic        tsel_q;

    // Idle-high line: synchronizer resets to 1 so reset release never looks like a start bit.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (clk_in),
        .rst_ni (reset),
        .d_i    (Rx_in),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            data_q        <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            start_cmd_q   <= 1'b0;
            unknown_cmd_q <= 1'b0;
            tsel_q        <= 1'b0;
        end else begin
            // Pulse outputs are high for exactly one cycle.
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            start_cmd_q   <= 1'b0;
            unknown_cmd_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= 16'd0;
                    end
                end

                ST_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= 16'd0;
                        bit_idx_q <= 3'd0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= 16'd0;
                        shift_q <= {rx_s, shift_q[7:1]};  // LSB arrives first
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= 16'd0;
                        if (rx_s) begin
                            state_q    <= ST_IDLE;
                            data_q     <= shift_q;
                            rx_valid_q <= 1'b1;
                            if (shift_q == CMD_START) begin
                                start_cmd_q <= 1'b1;
                            end else if (shift_q == CMD_T0) begin
                                tsel_q <= 1'b0;
                            end else if (shift_q == CMD_T1) begin
                                tsel_q <= 1'b1;
                            end else begin
                                unknown_cmd_q <= 1'b1;
                            end
                        end else begin
                            // Framing error or break: wait for the line to go idle
                            // so a held-low line is not mistaken for new start bits.
                            state_q     <= ST_BREAK_WAIT;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_BREAK_WAIT: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign start_cmd   = start_cmd_q;
    assign unknown_cmd = unknown_cmd_q;
    assign T_frame_sel = tsel_q;
    assign busy        = (state_q != ST_IDLE);

endmodule : uart_cmd_rx

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a 16-cycle bit period.
// Drives serial frames on Rx_in, counts output pulses on the falling clock edge,
// and compares against hand-computed expectations.
module tb_uart_cmd_rx;

    localparam int C = 16;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       Rx_in  = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       start_cmd;
    logic       T_frame_sel;
    logic       unknown_cmd;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters, written only by the monitor below.
    int n_valid = 0;
    int n_ferr  = 0;
    int n_start = 0;
    int n_start_alone = 0;
    int n_unk   = 0;

    uart_cmd_rx #(
        .CLKS_PER_BIT (C),
        .CMD_START    (8'h53),
        .CMD_T0       (8'h30),
        .CMD_T1       (8'h31)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .Rx_in       (Rx_in),
        .data_out    (data_out),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .start_cmd   (start_cmd),
        .T_frame_sel (T_frame_sel),
        .unknown_cmd (unknown_cmd),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (rx_valid)               n_valid++;
        if (frame_err)              n_ferr++;
        if (start_cmd)              n_start++;
        if (start_cmd && !rx_valid) n_start_alone++;
        if (unknown_cmd)            n_unk++;
    end

    // Hold the line at a level for n clock cycles; returns #1 after a rising edge.
    task automatic drive_bits(input logic level, input int n);
        Rx_in = level;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, then the stop level for stop_cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop_level, input int stop_cycles);
        drive_bits(1'b0, C);
        for (int i = 0; i < 8; i++) drive_bits(b[i], C);
        drive_bits(stop_level, stop_cycles);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        Rx_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_checks++; if ({rx_valid, frame_err, start_cmd, unknown_cmd} !== 4'b0000) begin n_errors++; $display("FAIL reset_pulses: got %b expected 0000", {rx_valid, frame_err, start_cmd, unknown_cmd}); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (T_frame_sel !== 1'b0) begin n_errors++; $display("FAIL reset_tsel: got %b expected 0", T_frame_sel); end
        reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    // 0xA5 is not a command; also measures start-edge-to-rx_valid latency.
    task automatic test_a5_latency;
        int v0, u0, s0, f0, lat;
        bit found;
        v0 = n_valid; u0 = n_unk; s0 = n_start; f0 = n_ferr;
        lat = 0; found = 0;
        fork
            send_byte(8'hA5, 1'b1, C);
            begin
                while (!found && lat < 400) begin
                    @(posedge clk_in);
                    #1;
                    lat++;
                    if (rx_valid) found = 1;
                end
            end
        join
        drive_bits(1'b1, 10);
        n_checks++; if (!found) begin n_errors++; $display("FAIL a5_timeout: no rx_valid within %0d cycles", lat); end
        n_checks++; if (lat < 154 || lat > 156) begin n_errors++; $display("FAIL latency: got %0d expected 155+-1", lat); end
        n_checks++; if (n_valid - v0 !== 1) begin n_errors++; $display("FAIL a5_valid_count: got %0d expected 1", n_valid - v0); end
        n_checks++; if (data_out !== 8'hA5) begin n_errors++; $display("FAIL a5_data: got %h expected a5", data_out); end
        n_checks++; if (n_unk - u0 !== 1) begin n_errors++; $display("FAIL a5_unknown: got %0d expected 1", n_unk - u0); end
        n_checks++; if (n_start - s0 !== 0) begin n_errors++; $display("FAIL a5_start: got %0d expected 0", n_start - s0); end
        n_checks++; if (n_ferr - f0 !== 0) begin n_errors++; $display("FAIL a5_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

    task automatic test_back_to_back;
        int v0, u0, s0;
        v0 = n_valid; u0 = n_unk; s0 = n_start;
        send_byte(8'h53, 1'b1, C);
        n_checks++; if (n_start - s0 !== 1) begin n_errors++; $display("FAIL b2b_start_count: got %0d expected 1", n_start - s0); end
        n_checks++; if (T_frame_sel !== 1'b0) begin n_errors++; $display("FAIL b2b_tsel_mid: got %b expected 0", T_frame_sel); end
        send_byte(8'h31, 1'b1, C);
        drive_bits(1'b1, 10);
        n_checks++; if (n_valid - v0 !== 2) begin n_errors++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0); end
        n_checks++; if (n_start - s0 !== 1) begin n_errors++; $display("FAIL b2b_start_total: got %0d expected 1", n_start - s0); end
        n_checks++; if (n_start_alone !== 0) begin n_errors++; $display("FAIL b2b_start_align: got %0d expected 0", n_start_alone); end
        n_checks++; if (T_frame_sel !== 1'b1) begin n_errors++; $display("FAIL b2b_tsel: got %b expected 1", T_frame_sel); end
        n_checks++; if (data_out !== 8'h31) begin n_errors++; $display("FAIL b2b_data: got %h expected 31", data_out); end
        n_checks++; if (n_unk - u0 !== 0) begin n_errors++; $display("FAIL b2b_unknown: got %0d expected 0", n_unk - u0); end
    endtask

    task automatic test_tsel;
        send_byte(8'h30, 1'b1, C);
        drive_bits(1'b1, 10);
        n_checks++; if (T_frame_sel !== 1'b0) begin n_errors++; $display("FAIL tsel_t0: got %b expected 0", T_frame_sel); end
        send_byte(8'h31, 1'b1, C);
        drive_bits(1'b1, 10);
        n_checks++; if (T_frame_sel !== 1'b1) begin n_errors++; $display("FAIL tsel_t1: got %b expected 1", T_frame_sel); end
    endtask

    task automatic test_glitch;
        int v0, f0, s0, u0;
        v0 = n_valid; f0 = n_ferr; s0 = n_start; u0 = n_unk;
        drive_bits(1'b0, 5);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
        drive_bits(1'b1, 9);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
        drive_bits(1'b1, 200);
        n_checks++; if ((n_valid - v0) + (n_ferr - f0) + (n_start - s0) + (n_unk - u0) !== 0) begin n_errors++; $display("FAIL glitch_pulses: got %0d expected 0", (n_valid - v0) + (n_ferr - f0) + (n_start - s0) + (n_unk - u0)); end
        n_checks++; if (data_out !== 8'h31) begin n_errors++; $display("FAIL glitch_data: got %h expected 31", data_out); end
    endtask

    // 0x30 would clear T_frame_sel if it were decoded despite the bad stop bit.
    task automatic test_break;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h30, 1'b0, 3 * C);
        n_checks++; if (n_ferr - f0 !== 1) begin n_errors++; $display("FAIL break_ferr: got %0d expected 1", n_ferr - f0); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL break_busy_held: got %b expected 1", busy); end
        drive_bits(1'b1, 6);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL break_idle: got %b expected 0", busy); end
        n_checks++; if (n_valid - v0 !== 0) begin n_errors++; $display("FAIL break_valid: got %0d expected 0", n_valid - v0); end
        n_checks++; if (data_out !== 8'h31) begin n_errors++; $display("FAIL break_data: got %h expected 31", data_out); end
        n_checks++; if (T_frame_sel !== 1'b1) begin n_errors++; $display("FAIL break_tsel: got %b expected 1", T_frame_sel); end
    endtask

    task automatic test_reset_midframe;
        int v0, u0;
        v0 = n_valid;
        drive_bits(1'b0, C);
        drive_bits(1'b1, 4 * C + C / 2);   // bits 0..3 of 0xFF, now inside bit 4
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++; if ({busy, T_frame_sel, data_out} !== 10'h000) begin n_errors++; $display("FAIL mid_reset_state: got %h expected 000", {busy, T_frame_sel, data_out}); end
        reset = 1'b1;
        drive_bits(1'b1, 4 * C);           // rest of the aborted frame
        n_checks++; if (n_valid - v0 !== 0) begin n_errors++; $display("FAIL mid_partial_valid: got %0d expected 0", n_valid - v0); end
        u0 = n_unk;
        send_byte(8'h31, 1'b1, C);
        drive_bits(1'b1, 10);
        n_checks++; if (n_valid - v0 !== 1) begin n_errors++; $display("FAIL mid_valid: got %0d expected 1", n_valid - v0); end
        n_checks++; if (data_out !== 8'h31) begin n_errors++; $display("FAIL mid_data: got %h expected 31", data_out); end
        n_checks++; if (T_frame_sel !== 1'b1) begin n_errors++; $display("FAIL mid_tsel: got %b expected 1", T_frame_sel); end
        n_checks++; if (n_unk - u0 !== 0) begin n_errors++; $display("FAIL mid_unknown: got %0d expected 0", n_unk - u0); end
    endtask

    initial begin
        test_reset();
        test_a5_latency();
        test_back_to_back();
        test_tsel();
        test_glitch();
        test_break();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_cmd_rx

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk_in cycles per UART bit (9600 baud at 50 MHz); legal range 16..65535.
REQ-002 The block SHALL have parameter CMD_START, default 8'h53, meaning the byte code that requests a measurement start.
REQ-003 The block SHALL have parameter CMD_T0, default 8'h30, meaning the byte code that selects the 0.1 s frame.
REQ-004 The block SHALL have parameter CMD_T1, default 8'h31, meaning the byte code that selects the 1 s frame.
REQ-005 Port clk_in  input  1  the single system clock, 50 MHz.
REQ-006 Port reset  input  1  asynchronous active-low reset.
REQ-007 Port Rx_in  input  1  asynchronous UART serial line, idle high.
REQ-008 Port data_out  output  8  the last correctly framed byte received.
REQ-009 Port rx_valid  output  1  one-cycle pulse marking that data_out has been updated.
REQ-010 Port frame_err  output  1  one-cycle pulse marking a stop bit sampled low.
REQ-011 Port start_cmd  output  1  one-cycle pulse on reception of CMD_START.
REQ-012 Port T_frame_sel  output  1  level output: 0 selects the 0.1 s frame, 1 selects the 1 s frame.
REQ-013 Port unknown_cmd  output  1  one-cycle pulse on reception of a valid byte matching no command.
REQ-014 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Rx_in SHALL pass through a two-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-016 The FSM SHALL have exactly the states IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-017 In IDLE, rx_s = 0 SHALL cause a move to START with the bit counter cleared.
REQ-018 START SHALL sample rx_s at count CLKS_PER_BIT/2-1 (integer division); a 0 SHALL move to DATA, and a 1 (glitch) SHALL return to IDLE with no output pulse.
REQ-019 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample, into a shift register, using a 3-bit bit index.
REQ-020 After the 8th data sample the FSM SHALL enter STOP and sample CLKS_PER_BIT cycles later.
REQ-021 If the stop sample is 1, data_out SHALL load the shift register and rx_valid SHALL pulse in the cycle after the stop sample, and the FSM SHALL return to IDLE.
REQ-022 If the stop sample is 0, frame_err SHALL pulse, data_out SHALL stay unchanged, no command SHALL be decoded, and the FSM SHALL enter BREAK_WAIT.
REQ-023 BREAK_WAIT SHALL stay until rx_s = 1, then go to IDLE.
REQ-024 Command decode SHALL act only in the rx_valid cycle: CMD_START pulses start_cmd in the same cycle as rx_valid; CMD_T0 and CMD_T1 update T_frame_sel in that cycle; any other byte pulses unknown_cmd.
REQ-025 Total latency from the falling edge of the start bit on Rx_in to rx_valid SHALL be 9.5*CLKS_PER_BIT + 3 (±1) cycles.
REQ-026 The baud counter SHALL be 16 bits and SHALL reset to 0 on every sample, so there is no wrap-around dependency.
REQ-027 A byte that starts immediately after a stop bit (back-to-back frames) SHALL be received with no loss.

Reset
REQ-028 Asserting reset low at any time, including mid-frame, SHALL force IDLE and clear the counters, shift register and synchronizer flops (synchronizer flops to 1).
REQ-029 During reset, outputs SHALL be: data_out = 8'h00, rx_valid = 0, frame_err = 0, start_cmd = 0, unknown_cmd = 0, busy = 0, T_frame_sel = 0.
REQ-030 After reset is released, a partial frame SHALL never produce rx_valid.

Structure
REQ-031 The command codes, the default CLKS_PER_BIT and the state encoding constants SHALL live in the shared package uart_pkg, which the transmitter side also uses.
REQ-032 The two-flop synchronizer SHALL be the sub-module sync_2ff; everything else SHALL stay in uart_cmd_rx.

Verification (CLKS_PER_BIT = 16 in the bench)
REQ-033 Send byte 8'hA5 correctly framed -> one rx_valid pulse, data_out = 8'hA5, unknown_cmd pulses, start_cmd stays 0.
REQ-034 Send 8'h53, then 8'h31 back-to-back -> start_cmd pulses once, T_frame_sel goes to 1 after the second byte, two rx_valid pulses in total.
REQ-035 Drive Rx_in low for 5 cycles only, then high -> no pulses, busy returns to 0 within 9 cycles.
REQ-036 Send 8'h30 with the stop bit held low for 3 bit times -> frame_err pulses once, data_out unchanged, T_frame_sel unchanged, IDLE entered only after the line returns high.
REQ-037 Assert reset during data bit 4 of 8'hFF, release it, then send 8'h31 -> only 8'h31 is reported, T_frame_sel = 1.
REQ-038 Check that latency from the start-bit edge to rx_valid is 155 ±1 cycles.
